// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: decode-side request, execute-side response and flush.
// Forwarding signals exist only when ID_EX_FWD_EN is defined.
interface id_ex_stage_if #(
    parameter int unsigned DW    = 32,
    parameter int unsigned RW    = 5,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic             alu_src_sel;
    logic [DW-1:0]    rs1_data;
    logic [DW-1:0]    rs2_data;
    logic [15:0]      imm;
    logic [RW-1:0]    rd_in;
    logic             reg_write_in;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       alu_ct;
    logic [DW-1:0]    alu_src1;
    logic [DW-1:0]    alu_src2;
    logic [RW-1:0]    rd_out;
    logic             reg_write_out;
    logic             illegal;
    logic [CNT_W-1:0] stall_cnt;
`ifdef ID_EX_FWD_EN
    logic             fwd_wr;
    logic [RW-1:0]    fwd_rd;
    logic [DW-1:0]    fwd_data;
    logic [RW-1:0]    rs1_addr;
    logic [RW-1:0]    rs2_addr;
`endif

    // Driver view: decode stage plus execute-side consumer.
    modport master (
`ifdef ID_EX_FWD_EN
        output fwd_wr,
        output fwd_rd,
        output fwd_data,
        output rs1_addr,
        output rs2_addr,
`endif
        output in_valid,
        input  in_ready,
        output alu_op,
        output funct,
        output alu_src_sel,
        output rs1_data,
        output rs2_data,
        output imm,
        output rd_in,
        output reg_write_in,
        output flush,
        input  out_valid,
        output out_ready,
        input  alu_ct,
        input  alu_src1,
        input  alu_src2,
        input  rd_out,
        input  reg_write_out,
        input  illegal,
        input  stall_cnt
    );

    // Pipeline-register view.
    modport slave (
`ifdef ID_EX_FWD_EN
        input  fwd_wr,
        input  fwd_rd,
        input  fwd_data,
        input  rs1_addr,
        input  rs2_addr,
`endif
        input  in_valid,
        output in_ready,
        input  alu_op,
        input  funct,
        input  alu_src_sel,
        input  rs1_data,
        input  rs2_data,
        input  imm,
        input  rd_in,
        input  reg_write_in,
        input  flush,
        output out_valid,
        input  out_ready,
        output alu_ct,
        output alu_src1,
        output alu_src2,
        output rd_out,
        output reg_write_out,
        output illegal,
        output stall_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: ALU-control decode, operand-2 select,
// valid/ready handshake with flush and saturating stall counter. ID_EX_FWD_EN adds forwarding.
module id_ex_stage #(
    parameter int unsigned DW    = 32,
    parameter int unsigned RW    = 5,
    parameter int unsigned CNT_W = 16
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    localparam logic [3:0] CtNone = 4'b0000;
    localparam logic [3:0] CtAdd  = 4'b0010;
    localparam logic [3:0] CtSub  = 4'b0110;
    localparam logic [5:0] FnAdd  = 6'b100000;
    localparam logic [5:0] FnSub  = 6'b100010;

    logic             out_valid_q, out_valid_d;
    logic [3:0]       alu_ct_q, alu_ct_d;
    logic [DW-1:0]    alu_src1_q, alu_src1_d;
    logic [DW-1:0]    alu_src2_q, alu_src2_d;
    logic [RW-1:0]    rd_q, rd_d;
    logic             reg_write_q, reg_write_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             in_ready;
    logic             load;
    logic [3:0]       dec_ct;
    logic             dec_illegal;
    logic [DW-1:0]    op1;
    logic [DW-1:0]    op2;
    logic [DW-1:0]    imm_ext;

    assign in_ready = !out_valid_q || bus.out_ready;
    assign load     = bus.in_valid && in_ready && !bus.flush;
    assign imm_ext  = {{(DW-16){bus.imm[15]}}, bus.imm};

    always_comb begin
        dec_ct      = CtNone;
        dec_illegal = 1'b0;
        case (bus.alu_op)
            2'b00: dec_ct = CtAdd;
            2'b01: dec_ct = CtSub;
            2'b10: begin
                if (bus.funct == FnAdd) begin
                    dec_ct = CtAdd;
                end else if (bus.funct == FnSub) begin
                    dec_ct = CtSub;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

`ifdef ID_EX_FWD_EN
    logic fwd_live;
    assign fwd_live = bus.fwd_wr && (bus.fwd_rd != '0);
    // Forwarding substitutes register operands only; the immediate is never replaced.
    assign op1 = (fwd_live && bus.rs1_addr == bus.fwd_rd) ? bus.fwd_data : bus.rs1_data;
    assign op2 = (fwd_live && bus.rs2_addr == bus.fwd_rd) ? bus.fwd_data : bus.rs2_data;
`else
    assign op1 = bus.rs1_data;
    assign op2 = bus.rs2_data;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        alu_ct_d    = alu_ct_q;
        alu_src1_d  = alu_src1_q;
        alu_src2_d  = alu_src2_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        illegal_d   = illegal_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
            reg_write_d = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
            alu_ct_d    = dec_ct;
            alu_src1_d  = op1;
            alu_src2_d  = bus.alu_src_sel ? imm_ext : op2;
            rd_d        = bus.rd_in;
            reg_write_d = bus.reg_write_in && !dec_illegal;
            illegal_d   = dec_illegal;
        end else if (out_valid_q && bus.out_ready) begin
            // Drain: data registers hold, but nothing may write back.
            out_valid_d = 1'b0;
            reg_write_d = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !bus.out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            alu_ct_q    <= CtNone;
            alu_src1_q  <= '0;
            alu_src2_q  <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            alu_ct_q    <= alu_ct_d;
            alu_src1_q  <= alu_src1_d;
            alu_src2_q  <= alu_src2_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.alu_ct        = alu_ct_q;
    assign bus.alu_src1      = alu_src1_q;
    assign bus.alu_src2      = alu_src2_q;
    assign bus.rd_out        = rd_q;
    assign bus.reg_write_out = reg_write_q;
    assign bus.illegal       = illegal_q;
    assign bus.stall_cnt     = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a narrow stall counter keeps the saturation check short.
module tb_id_ex_stage;
    localparam int unsigned DW    = 32;
    localparam int unsigned RW    = 5;
    localparam int unsigned CNT_W = 4;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    id_ex_stage_if #(.DW(DW), .RW(RW), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.DW(DW), .RW(RW), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [1:0] op, input logic [5:0] fn, input logic sel,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [15:0] im,
                         input logic [4:0] rd, input logic rw);
        bus.in_valid     = 1'b1;
        bus.alu_op       = op;
        bus.funct        = fn;
        bus.alu_src_sel  = sel;
        bus.rs1_data     = r1;
        bus.rs2_data     = r2;
        bus.imm          = im;
        bus.rd_in        = rd;
        bus.reg_write_in = rw;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, ".alu_ct"}, {28'd0, bus.alu_ct}, 32'd0);
        chk({tag, ".alu_src1"}, bus.alu_src1, 32'd0);
        chk({tag, ".alu_src2"}, bus.alu_src2, 32'd0);
        chk({tag, ".rd_out"}, {27'd0, bus.rd_out}, 32'd0);
        chk({tag, ".reg_write_out"}, {31'd0, bus.reg_write_out}, 32'd0);
        chk({tag, ".illegal"}, {31'd0, bus.illegal}, 32'd0);
        chk({tag, ".stall_cnt"}, {28'd0, bus.stall_cnt}, 32'd0);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.alu_op   = 2'b00;
        bus.funct    = 6'd0;
        bus.alu_src_sel  = 1'b0;
        bus.rs1_data     = '0;
        bus.rs2_data     = '0;
        bus.imm          = '0;
        bus.rd_in        = '0;
        bus.reg_write_in = 1'b0;
        bus.flush        = 1'b0;
        bus.out_ready    = 1'b1;
`ifdef ID_EX_FWD_EN
        bus.fwd_wr   = 1'b0;
        bus.fwd_rd   = '0;
        bus.fwd_data = '0;
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
`endif
        #2 rst = 1'b0;
        #1;
        chk_reset("por");
        chk("por.in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        #2 rst = 1'b1;

        // R-type sub
        instr(2'b10, 6'b100010, 1'b0, 32'h9, 32'h4, 16'h0, 5'd3, 1'b1);
        step();
        chk("rsub.out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("rsub.alu_ct", {28'd0, bus.alu_ct}, 32'h6);
        chk("rsub.alu_src1", bus.alu_src1, 32'h9);
        chk("rsub.alu_src2", bus.alu_src2, 32'h4);
        chk("rsub.rd_out", {27'd0, bus.rd_out}, 32'd3);
        chk("rsub.reg_write_out", {31'd0, bus.reg_write_out}, 32'd1);
        chk("rsub.illegal", {31'd0, bus.illegal}, 32'd0);

        // Immediate path with negative imm
        instr(2'b00, 6'b000000, 1'b1, 32'h10, 32'h1234, 16'hFFFE, 5'd7, 1'b1);
        step();
        chk("imm.alu_ct", {28'd0, bus.alu_ct}, 32'h2);
        chk("imm.alu_src1", bus.alu_src1, 32'h10);
        chk("imm.alu_src2", bus.alu_src2, 32'hFFFF_FFFE);
        chk("imm.rd_out", {27'd0, bus.rd_out}, 32'd7);

        // Backpressure for three cycles while a new instruction waits
        bus.out_ready = 1'b0;
        instr(2'b01, 6'b000000, 1'b0, 32'h55, 32'h22, 16'h0, 5'd9, 1'b1);
        #1;
        chk("bp.in_ready", {31'd0, bus.in_ready}, 32'd0);
        step();
        step();
        step();
        chk("bp.stall_cnt", {28'd0, bus.stall_cnt}, 32'd3);
        chk("bp.alu_src1", bus.alu_src1, 32'h10);
        chk("bp.alu_src2", bus.alu_src2, 32'hFFFF_FFFE);
        chk("bp.alu_ct", {28'd0, bus.alu_ct}, 32'h2);
        chk("bp.out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp.in_ready2", {31'd0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        step();
        chk("bprel.alu_ct", {28'd0, bus.alu_ct}, 32'h6);
        chk("bprel.alu_src1", bus.alu_src1, 32'h55);
        chk("bprel.alu_src2", bus.alu_src2, 32'h22);
        chk("bprel.rd_out", {27'd0, bus.rd_out}, 32'd9);
        chk("bprel.stall_cnt", {28'd0, bus.stall_cnt}, 32'd3);

        // Drain with no new instruction
        bus.in_valid = 1'b0;
        step();
        chk("drain.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("drain.reg_write_out", {31'd0, bus.reg_write_out}, 32'd0);
        chk("drain.alu_src1", bus.alu_src1, 32'h55);

        // Flush beats a coincident load
        instr(2'b00, 6'b000000, 1'b0, 32'h1, 32'h2, 16'h0, 5'd4, 1'b1);
        step();
        chk("preflush.out_valid", {31'd0, bus.out_valid}, 32'd1);
        instr(2'b01, 6'b000000, 1'b0, 32'hAA, 32'hBB, 16'h0, 5'd5, 1'b1);
        bus.flush = 1'b1;
        step();
        chk("flush.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush.reg_write_out", {31'd0, bus.reg_write_out}, 32'd0);
        chk("flush.alu_src1", bus.alu_src1, 32'h1);
        bus.in_valid = 1'b0;
        step();
        chk("flushempty.out_valid", {31'd0, bus.out_valid}, 32'd0);
        bus.flush = 1'b0;

        // Illegal encodings still flow but never write back
        instr(2'b11, 6'b100000, 1'b0, 32'h3, 32'h4, 16'h0, 5'd6, 1'b1);
        step();
        chk("ill11.out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("ill11.illegal", {31'd0, bus.illegal}, 32'd1);
        chk("ill11.alu_ct", {28'd0, bus.alu_ct}, 32'h0);
        chk("ill11.reg_write_out", {31'd0, bus.reg_write_out}, 32'd0);
        instr(2'b10, 6'b100100, 1'b0, 32'h3, 32'h4, 16'h0, 5'd6, 1'b1);
        step();
        chk("illfn.illegal", {31'd0, bus.illegal}, 32'd1);
        chk("illfn.alu_ct", {28'd0, bus.alu_ct}, 32'h0);
        instr(2'b10, 6'b100000, 1'b0, 32'h3, 32'h4, 16'h0, 5'd6, 1'b1);
        step();
        chk("radd.illegal", {31'd0, bus.illegal}, 32'd0);
        chk("radd.alu_ct", {28'd0, bus.alu_ct}, 32'h2);
        chk("radd.reg_write_out", {31'd0, bus.reg_write_out}, 32'd1);

        // Asynchronous reset while holding a stalled instruction
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();
        #2 rst = 1'b0;
        #1;
        chk_reset("midrst");
        #1 rst = 1'b1;

        // Saturation of the narrow stall counter
        instr(2'b00, 6'b000000, 1'b0, 32'h7, 32'h8, 16'h0, 5'd1, 1'b1);
        step();
        chk("sat.load", {31'd0, bus.out_valid}, 32'd1);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("sat.max", {28'd0, bus.stall_cnt}, 32'd15);
        for (int i = 0; i < 5; i++) step();
        chk("sat.hold", {28'd0, bus.stall_cnt}, 32'd15);
        bus.out_ready = 1'b1;
        step();

`ifdef ID_EX_FWD_EN
        instr(2'b00, 6'b000000, 1'b0, 32'h11, 32'h22, 16'h0, 5'd2, 1'b1);
        bus.rs1_addr = 5'd5;
        bus.rs2_addr = 5'd6;
        bus.fwd_wr   = 1'b1;
        bus.fwd_rd   = 5'd5;
        bus.fwd_data = 32'hDEAD_BEEF;
        step();
        chk("fwd.alu_src1", bus.alu_src1, 32'hDEAD_BEEF);
        chk("fwd.alu_src2", bus.alu_src2, 32'h22);
        bus.rs1_addr = 5'd0;
        bus.fwd_rd   = 5'd0;
        step();
        chk("fwd0.alu_src1", bus.alu_src1, 32'h11);
        bus.rs2_addr = 5'd6;
        bus.fwd_rd   = 5'd6;
        bus.alu_src_sel = 1'b1;
        bus.imm      = 16'h0040;
        step();
        chk("fwdimm.alu_src2", bus.alu_src2, 32'h40);
        bus.alu_src_sel = 1'b0;
        step();
        chk("fwd2.alu_src2", bus.alu_src2, 32'hDEAD_BEEF);
        bus.in_valid = 1'b0;
        bus.fwd_wr   = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
